// File: rtl/ac_cmd_encoder.sv
// Air-conditioner remote command encoder: debounced keys drive a small state
// machine whose state is framed into 35+32 bit halves. Optional macro AC_AUTO_REPEAT_EN.
module ac_cmd_encoder #(
    parameter int DEBOUNCE_CYCLES = 2500000,
    parameter int REPEAT_DELAY    = 62500000,
    parameter int REPEAT_PERIOD   = 31250000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_power,
    input  logic        key_mode,
    input  logic        key_fan,
    input  logic        key_temp_up,
    input  logic        key_temp_dn,
    output logic [34:0] cmd_data35,
    output logic [31:0] cmd_data32,
    output logic        cmd_valid,
    input  logic        cmd_ready
);

    localparam int NKEYS       = 5;
    localparam int KEY_POWER   = 0;
    localparam int KEY_MODE    = 1;
    localparam int KEY_FAN     = 2;
    localparam int KEY_TEMP_UP = 3;
    localparam int KEY_TEMP_DN = 4;
    localparam int DEB_W       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [2:0]  MODE_RESET = 3'd1;
    localparam logic [3:0]  TEMP_RESET = 4'd10;
    localparam logic [3:0]  TEMP_MAX   = 4'd14;
    localparam logic [22:0] D35_TAIL   = 23'b00000000010000001010010;
    localparam logic [27:0] D32_TAIL   = 28'h000000C;

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_params
        $error("ac_cmd_encoder: timing parameters must be at least 2");
    end

    logic [NKEYS-1:0] key_raw;
    logic [NKEYS-1:0] key_event;

    assign key_raw = {key_temp_dn, key_temp_up, key_fan, key_mode, key_power};

    genvar gi;
    generate
        for (gi = 0; gi < NKEYS; gi++) begin : g_key
            logic             sync1_reg;
            logic             sync2_reg;
            logic             deb_reg;
            logic             deb_prev_reg;
            logic [DEB_W-1:0] deb_cnt_reg;
            logic             deb_rise;

            // Debounced level flips only once the synchronized input has
            // disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sync1_reg    <= 1'b0;
                    sync2_reg    <= 1'b0;
                    deb_reg      <= 1'b0;
                    deb_prev_reg <= 1'b0;
                    deb_cnt_reg  <= '0;
                end else begin
                    sync1_reg    <= key_raw[gi];
                    sync2_reg    <= sync1_reg;
                    deb_prev_reg <= deb_reg;
                    if (sync2_reg == deb_reg) begin
                        deb_cnt_reg <= '0;
                    end else if (deb_cnt_reg == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                        deb_reg     <= sync2_reg;
                        deb_cnt_reg <= '0;
                    end else begin
                        deb_cnt_reg <= deb_cnt_reg + 1'b1;
                    end
                end
            end

            assign deb_rise = deb_reg & ~deb_prev_reg;

`ifdef AC_AUTO_REPEAT_EN
            if (gi == KEY_TEMP_UP || gi == KEY_TEMP_DN) begin : g_rpt
                localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
                localparam int RPT_W   = $clog2(RPT_MAX);

                logic [RPT_W-1:0] rpt_cnt_reg;
                logic             rpt_armed_reg;
                logic [RPT_W-1:0] rpt_limit;
                logic             rpt_pulse;

                // Counter restarts at each repeat; the first interval is the longer delay.
                assign rpt_limit = rpt_armed_reg ? RPT_W'(REPEAT_PERIOD - 1) : RPT_W'(REPEAT_DELAY - 1);
                assign rpt_pulse = deb_reg && (rpt_cnt_reg == rpt_limit);

                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        rpt_cnt_reg   <= '0;
                        rpt_armed_reg <= 1'b0;
                    end else if (!deb_reg) begin
                        rpt_cnt_reg   <= '0;
                        rpt_armed_reg <= 1'b0;
                    end else if (rpt_pulse) begin
                        rpt_cnt_reg   <= '0;
                        rpt_armed_reg <= 1'b1;
                    end else begin
                        rpt_cnt_reg   <= rpt_cnt_reg + 1'b1;
                    end
                end

                assign key_event[gi] = deb_rise | rpt_pulse;
            end else begin : g_norpt
                assign key_event[gi] = deb_rise;
            end
`else
            assign key_event[gi] = deb_rise;
`endif
        end
    endgenerate

    logic       power_reg, power_next;
    logic [2:0] mode_reg, mode_next;
    logic [1:0] fan_reg, fan_next;
    logic [3:0] temp_reg, temp_next;
    logic       build_req_reg, build_req_next;
    logic [3:0] checksum;

    always_comb begin
        power_next     = power_reg;
        mode_next      = mode_reg;
        fan_next       = fan_reg;
        temp_next      = temp_reg;
        build_req_next = 1'b0;
        if (key_event[KEY_POWER]) begin
            power_next     = ~power_reg;
            build_req_next = 1'b1;
        end else if (power_reg) begin
            if (key_event[KEY_MODE]) begin
                mode_next = (mode_reg == 3'd4) ? 3'd0 : mode_reg + 3'd1;
            end else if (key_event[KEY_FAN]) begin
                fan_next = fan_reg + 2'd1;
            end else if (key_event[KEY_TEMP_UP]) begin
                temp_next = (temp_reg == TEMP_MAX) ? TEMP_MAX : temp_reg + 4'd1;
            end else if (key_event[KEY_TEMP_DN]) begin
                temp_next = (temp_reg == 4'd0) ? 4'd0 : temp_reg - 4'd1;
            end
            // Saturated temp presses still resend the unchanged frame.
            build_req_next = |key_event[KEY_TEMP_DN:KEY_MODE];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            power_reg     <= 1'b0;
            mode_reg      <= MODE_RESET;
            fan_reg       <= 2'd0;
            temp_reg      <= TEMP_RESET;
            build_req_reg <= 1'b0;
        end else begin
            power_reg     <= power_next;
            mode_reg      <= mode_next;
            fan_reg       <= fan_next;
            temp_reg      <= temp_next;
            build_req_reg <= build_req_next;
        end
    end

    assign checksum = {1'b0, mode_reg} + temp_reg + {3'b000, power_reg} + 4'd10;

    // A pending build overwrites any frame still waiting, so only the newest is sent.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_data35 <= '0;
            cmd_data32 <= '0;
            cmd_valid  <= 1'b0;
        end else if (build_req_reg) begin
            cmd_data35 <= {mode_reg, power_reg, fan_reg, 2'b00, temp_reg, D35_TAIL};
            cmd_data32 <= {checksum, D32_TAIL};
            cmd_valid  <= 1'b1;
        end else if (cmd_valid && cmd_ready) begin
            cmd_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ac_cmd_encoder.sv
// Directed bench for ac_cmd_encoder; define AC_AUTO_REPEAT_EN to also
// exercise the auto-repeat scenario.
module tb_ac_cmd_encoder;

    localparam int DEB  = 10;
    localparam int RDLY = 100;
    localparam int RPER = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  keys = 5'b0;
    logic        cmd_ready = 1'b0;
    logic [34:0] cmd_data35;
    logic [31:0] cmd_data32;
    logic        cmd_valid;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          xfer_cnt = 0;
    logic [34:0] last35 = '0;
    logic [31:0] last32 = '0;

    ac_cmd_encoder #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RDLY),
        .REPEAT_PERIOD  (RPER)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_power  (keys[0]),
        .key_mode   (keys[1]),
        .key_fan    (keys[2]),
        .key_temp_up(keys[3]),
        .key_temp_dn(keys[4]),
        .cmd_data35 (cmd_data35),
        .cmd_data32 (cmd_data32),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready)
    );

    always #5 clk = ~clk;

    // Outputs are stable between edges, so the negedge view is what the next posedge transfers.
    always @(negedge clk) begin
        if (rst && cmd_valid && cmd_ready) begin
            xfer_cnt++;
            last35 = cmd_data35;
            last32 = cmd_data32;
            $display("xfer %0d: data35=%09h data32=%08h", xfer_cnt, cmd_data35, cmd_data32);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int k);
        keys[k] = 1'b1;
        tick(DEB + 6);
        keys[k] = 1'b0;
        tick(DEB + 8);
    endtask

    function automatic logic [3:0] exp_chk(input int mode, input int temp, input int pwr);
        return 4'((mode + temp + pwr + 10) % 16);
    endfunction

    initial begin
        int code;
        logic seen_valid;

        cmd_ready = 1'b1;
        tick(3);
        check_eq("rst_valid", 64'(cmd_valid), 64'd0);
        check_eq("rst_d35", 64'(cmd_data35), 64'd0);
        check_eq("rst_d32", 64'(cmd_data32), 64'd0);
        rst = 1'b1;
        tick(5);
        check_eq("rel_noframe", 64'(xfer_cnt), 64'd0);

        press(0);
        check_eq("pwr_xfers", 64'(xfer_cnt), 64'd1);
        check_eq("pwr_fields", 64'(last35[34:23]), 64'(12'b001_1_00_00_1010));
        check_eq("pwr_tail35", 64'(last35[22:0]), 64'(23'b00000000010000001010010));
        check_eq("pwr_d32", 64'(last32), 64'h6000000C);
        check_eq("pwr_valid_clr", 64'(cmd_valid), 64'd0);

        press(3);
        check_eq("up_xfers", 64'(xfer_cnt), 64'd2);
        check_eq("up_temp", 64'(last35[26:23]), 64'd11);
        check_eq("up_chk", 64'(last32[31:28]), 64'h7);

        press(0);
        check_eq("off_xfers", 64'(xfer_cnt), 64'd3);
        check_eq("off_power", 64'(last35[31]), 64'd0);
        check_eq("off_chk", 64'(last32[31:28]), 64'(exp_chk(1, 11, 0)));

        press(3);
        check_eq("off_up_noframe", 64'(xfer_cnt), 64'd3);

        press(0);
        check_eq("on_xfers", 64'(xfer_cnt), 64'd4);
        check_eq("on_temp_kept", 64'(last35[26:23]), 64'd11);
        check_eq("on_chk", 64'(last32[31:28]), 64'h7);

        press(4);
        check_eq("dn_temp", 64'(last35[26:23]), 64'd10);
        check_eq("dn_chk", 64'(last32[31:28]), 64'h6);

        for (int i = 0; i < 6; i++) begin
            press(3);
            code = (11 + i > 14) ? 14 : 11 + i;
            check_eq("sat_xfers", 64'(xfer_cnt), 64'(6 + i));
            check_eq("sat_temp", 64'(last35[26:23]), 64'(code));
            check_eq("sat_chk", 64'(last32[31:28]), 64'(exp_chk(1, code, 1)));
        end

        seen_valid = 1'b0;
        keys[1] = 1'b1;
        tick(DEB - 1);
        keys[1] = 1'b0;
        for (int i = 0; i < DEB + 8; i++) begin
            tick(1);
            seen_valid = seen_valid | cmd_valid;
        end
        check_eq("glitch_valid", 64'(seen_valid), 64'd0);
        check_eq("glitch_xfers", 64'(xfer_cnt), 64'd11);

        cmd_ready = 1'b0;
        press(1);
        press(2);
        check_eq("hold_valid", 64'(cmd_valid), 64'd1);
        check_eq("hold_xfers", 64'(xfer_cnt), 64'd11);
        check_eq("hold_mode", 64'(cmd_data35[34:32]), 64'd2);
        check_eq("hold_fan", 64'(cmd_data35[30:29]), 64'd1);
        cmd_ready = 1'b1;
        tick(5);
        check_eq("one_xfer", 64'(xfer_cnt), 64'd12);
        check_eq("xfer_mode", 64'(last35[34:32]), 64'd2);
        check_eq("xfer_fan", 64'(last35[30:29]), 64'd1);
        check_eq("xfer_valid_clr", 64'(cmd_valid), 64'd0);

        cmd_ready = 1'b0;
        press(2);
        check_eq("pend_valid", 64'(cmd_valid), 64'd1);
        keys[3] = 1'b1;
        tick(5);
        rst = 1'b0;
        tick(2);
        keys[3] = 1'b0;
        check_eq("midrst_valid", 64'(cmd_valid), 64'd0);
        check_eq("midrst_d35", 64'(cmd_data35), 64'd0);
        rst = 1'b1;
        cmd_ready = 1'b1;
        tick(DEB + 8);
        check_eq("postrst_xfers", 64'(xfer_cnt), 64'd12);
        check_eq("postrst_valid", 64'(cmd_valid), 64'd0);

        press(0);
        check_eq("repwr_xfers", 64'(xfer_cnt), 64'd13);
        check_eq("repwr_fields", 64'(last35[34:23]), 64'(12'b001_1_00_00_1010));
        check_eq("repwr_chk", 64'(last32[31:28]), 64'h6);

`ifdef AC_AUTO_REPEAT_EN
        keys[4] = 1'b1;
        tick(2 + DEB + 260);
        keys[4] = 1'b0;
        tick(DEB + 8);
        check_eq("rpt_xfers", 64'(xfer_cnt), 64'd18);
        check_eq("rpt_temp", 64'(last35[26:23]), 64'd5);
        check_eq("rpt_chk", 64'(last32[31:28]), 64'(exp_chk(1, 5, 1)));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
